// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: FSM encodings, counter width and default reset PC.
package fetch_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_WAIT  = 2'b01;
  localparam logic [1:0] ST_VALID = 2'b10;

  typedef enum logic [1:0] {
    FETCH_IDLE  = ST_IDLE,
    FETCH_WAIT  = ST_WAIT,
    FETCH_VALID = ST_VALID
  } fetch_state_e;

  localparam int unsigned PC_INCR          = 4;
  localparam int unsigned WAIT_CNT_W       = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// PC register plus fixed-latency imem fetch, handing words to decode over valid/ready.
// Optional macro FETCH_MISALIGN_EN adds a sticky fetch_fault output and word-aligns redirect targets.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned        ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC  = ADDR_W'(DEFAULT_RESET_PC),
  parameter int unsigned        IMEM_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [1:0]        dbg_state
`ifdef FETCH_MISALIGN_EN
  , output logic            fetch_fault
`endif
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(IMEM_WAIT);
  localparam logic [ADDR_W-1:0]     PC_STEP   = ADDR_W'(PC_INCR);

  logic [ADDR_W-1:0]     r_pc;
  logic [31:0]           r_instr;
  logic [ADDR_W-1:0]     r_instr_pc;
  logic                  r_instr_valid;
  logic [1:0]            r_state;
  logic [WAIT_CNT_W-1:0] r_wait_cnt;

  logic                  w_handshake;
  logic [ADDR_W-1:0]     w_redirect_target;

  // Handshake: a word transfers on any clock where instr_valid and instr_ready are
  // both high; instr/instr_pc stay frozen while valid is high and ready is low.
  assign w_handshake = r_instr_valid & instr_ready;

`ifdef FETCH_MISALIGN_EN
  logic r_fetch_fault;
  assign w_redirect_target = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign fetch_fault       = r_fetch_fault;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_fault <= 1'b0;
    end else if (redirect_valid && is_misaligned(redirect_pc[1:0])) begin
      r_fetch_fault <= 1'b1;
    end
  end
`else
  assign w_redirect_target = redirect_pc;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_instr       <= 32'h0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
      r_state       <= ST_IDLE;
      r_wait_cnt    <= '0;
    end else if (redirect_valid) begin
      // Redirect wins over pc+4 even when the held word is accepted this cycle.
      r_pc          <= w_redirect_target;
      r_instr_valid <= 1'b0;
      r_wait_cnt    <= WAIT_LOAD;
      r_state       <= ST_WAIT;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_wait_cnt <= WAIT_LOAD;
          r_state    <= ST_WAIT;
        end
        ST_WAIT: begin
          r_wait_cnt <= r_wait_cnt - 1'b1;
          if (r_wait_cnt == WAIT_CNT_W'(1)) begin
            r_instr       <= imem_data;
            r_instr_pc    <= r_pc;
            r_instr_valid <= 1'b1;
            r_state       <= ST_VALID;
          end
        end
        ST_VALID: begin
          if (w_handshake) begin
            r_instr_valid <= 1'b0;
            r_pc          <= r_pc + PC_STEP;
            r_wait_cnt    <= WAIT_LOAD;
            r_state       <= ST_WAIT;
          end
        end
        default: begin
          r_instr_valid <= 1'b0;
          r_state       <= ST_IDLE;
        end
      endcase
    end
  end

  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign pc_plus4    = r_instr_pc + PC_STEP;
  assign instr_valid = r_instr_valid;
  assign dbg_state   = r_state;

endmodule
